dram_cmd_arbiter: RTL and testbench

Round-robin scheduler that shares the single DRAM command channel (cmd_rw stream: `cmd_valid`/`cmd_ready` plus `cmd_payload_*`) among up to eight per-bank command requesters. It sits between the bank machines and the multiplexer that drives the DFI phases. It registers the winning command, stamps the bank address from the grant index, and optionally groups CAS commands by direction to cut read/write turnarounds.

---
 rtl/dram_cmd_arbiter.sv | 130 +++++++++++++
 tb/tb_dram_cmd_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_cmd_arbiter.sv
// dram_cmd_arbiter: round-robin scheduler for the single DRAM command channel.
// Define CMD_ARB_RW_GROUP_EN to group CAS commands by read/write direction.
module dram_cmd_arbiter #(
    parameter int NUM_REQ    = 8,
    parameter int A_W        = 17,
    parameter int STREAK_MAX = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*A_W-1:0] req_a,
    input  logic [NUM_REQ-1:0]     req_cas,
    input  logic [NUM_REQ-1:0]     req_ras,
    input  logic [NUM_REQ-1:0]     req_we,
    input  logic [NUM_REQ-1:0]     req_is_cmd,
    input  logic [NUM_REQ-1:0]     req_is_read,
    input  logic [NUM_REQ-1:0]     req_is_write,
    input  logic [NUM_REQ-1:0]     req_is_mw,
    output logic                   cmd_valid,
    input  logic                   cmd_ready,
    output logic [A_W-1:0]         cmd_payload_a,
    output logic [2:0]             cmd_payload_ba,
    output logic                   cmd_payload_cas,
    output logic                   cmd_payload_ras,
    output logic                   cmd_payload_we,
    output logic                   cmd_payload_is_cmd,
    output logic                   cmd_payload_is_read,
    output logic                   cmd_payload_is_write,
    output logic                   cmd_payload_is_mw
);
    localparam logic [7:0] SMAX = 8'(STREAK_MAX);

    logic [NUM_REQ-1:0] elig;
    logic [2:0]         last_q;
    logic [2:0]         grant;
    logic               found;
    logic               load;
    logic               valid_q;
    logic [A_W-1:0]     a_q;
    logic [2:0]         ba_q;
    logic [6:0]         flags_q;

`ifdef CMD_ARB_RW_GROUP_EN
    logic               dir_q;
    logic [7:0]         streak_q;
    logic [NUM_REQ-1:0] is_cas;
    logic [NUM_REQ-1:0] same;
    logic [NUM_REQ-1:0] opp;
    logic               force_sw;

    assign is_cas = req_is_read | req_is_write;
    assign same   = req_valid & is_cas & (dir_q ? req_is_write : ~req_is_write);
    assign opp    = req_valid & is_cas & ~same;
    // Opposite direction only competes once the current one runs dry or hits its cap.
    assign force_sw = (|opp) && (!(|same) || (streak_q >= SMAX));
    assign elig     = (req_valid & ~is_cas) | (force_sw ? opp : same);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dir_q    <= 1'b0;
            streak_q <= '0;
        end else if (load && is_cas[grant]) begin
            if (req_is_write[grant] != dir_q) begin
                dir_q    <= ~dir_q;
                streak_q <= 8'd1;
            end else if (streak_q < SMAX) begin
                streak_q <= streak_q + 8'd1;
            end
        end
    end
`else
    logic unused_smax;
    assign unused_smax = ^SMAX;
    assign elig        = req_valid;
`endif

    always_comb begin
        int idx;
        idx   = 0;
        grant = last_q;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last_q) + k) % NUM_REQ;
            if (!found && elig[idx]) begin
                found = 1'b1;
                grant = 3'(idx);
            end
        end
    end

    assign load = found && (!valid_q || cmd_ready);

    always_comb begin
        req_ready = '0;
        if (load && rst) req_ready[grant] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            a_q     <= '0;
            ba_q    <= '0;
            flags_q <= '0;
            last_q  <= 3'(NUM_REQ - 1);
        end else if (load) begin
            valid_q <= 1'b1;
            a_q     <= req_a[int'(grant)*A_W +: A_W];
            ba_q    <= grant;
            flags_q <= {req_cas[grant], req_ras[grant], req_we[grant],
                        req_is_cmd[grant], req_is_read[grant],
                        req_is_write[grant], req_is_mw[grant]};
            last_q  <= grant;
        end else if (valid_q && cmd_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign cmd_valid            = valid_q;
    assign cmd_payload_a        = a_q;
    assign cmd_payload_ba       = ba_q;
    assign cmd_payload_cas      = flags_q[6];
    assign cmd_payload_ras      = flags_q[5];
    assign cmd_payload_we       = flags_q[4];
    assign cmd_payload_is_cmd   = flags_q[3];
    assign cmd_payload_is_read  = flags_q[2];
    assign cmd_payload_is_write = flags_q[1];
    assign cmd_payload_is_mw    = flags_q[0];

endmodule

// File: tb/tb_dram_cmd_arbiter.sv
// tb_dram_cmd_arbiter: directed and randomized checks of dram_cmd_arbiter
// against a queue-free behavioural model of the round-robin/grouping rules.
module tb_dram_cmd_arbiter;
    localparam int NUM  = 8;
    localparam int AW   = 17;
    localparam int SMAX = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NUM-1:0]    v = '0, rr;
    logic [NUM-1:0]    f_cas = '0, f_ras = '0, f_we = '0, f_cmd = '0;
    logic [NUM-1:0]    f_rd = '0, f_wr = '0, f_mw = '0;
    logic [NUM*AW-1:0] a = '0;
    logic              cmd_ready = 1'b0;
    logic              cmd_valid;
    logic [AW-1:0]     p_a;
    logic [2:0]        p_ba;
    logic p_cas, p_ras, p_we, p_cmd, p_rd, p_wr, p_mw;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    dram_cmd_arbiter #(.NUM_REQ(NUM), .A_W(AW), .STREAK_MAX(SMAX)) dut (
        .clk(clk), .rst(rst),
        .req_valid(v), .req_ready(rr), .req_a(a),
        .req_cas(f_cas), .req_ras(f_ras), .req_we(f_we),
        .req_is_cmd(f_cmd), .req_is_read(f_rd), .req_is_write(f_wr),
        .req_is_mw(f_mw),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_payload_a(p_a), .cmd_payload_ba(p_ba),
        .cmd_payload_cas(p_cas), .cmd_payload_ras(p_ras),
        .cmd_payload_we(p_we), .cmd_payload_is_cmd(p_cmd),
        .cmd_payload_is_read(p_rd), .cmd_payload_is_write(p_wr),
        .cmd_payload_is_mw(p_mw)
    );

    // Behavioural model state
    bit            m_valid  = 1'b0;
    logic [AW-1:0] m_a      = '0;
    logic [2:0]    m_ba     = '0;
    logic [6:0]    m_fl     = '0;
    int            m_last   = NUM - 1;
    bit            m_dir    = 1'b0;
    int            m_streak = 0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit elig(int i);
`ifdef CMD_ARB_RW_GROUP_EN
        bit same_p, opp_p;
        same_p = 1'b0;
        opp_p  = 1'b0;
        if (!v[i]) return 1'b0;
        if (!(f_rd[i] | f_wr[i])) return 1'b1;
        for (int j = 0; j < NUM; j++)
            if (v[j] && (f_rd[j] | f_wr[j])) begin
                if (f_wr[j] == m_dir) same_p = 1'b1;
                else opp_p = 1'b1;
            end
        if (f_wr[i] == m_dir) return !(m_streak == SMAX && opp_p);
        return !(same_p && m_streak < SMAX);
`else
        return v[i];
`endif
    endfunction

    function automatic int pick();
        for (int k = 1; k <= NUM; k++) begin
            int i;
            i = (m_last + k) % NUM;
            if (elig(i)) return i;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst) begin
        int w;
        if (!rst) begin
            m_valid = 1'b0; m_a = '0; m_ba = '0; m_fl = '0;
            m_last = NUM - 1; m_dir = 1'b0; m_streak = 0;
        end else begin
            w = pick();
            if (w >= 0 && (!m_valid || cmd_ready)) begin
                m_valid = 1'b1;
                m_a  = a[w*AW +: AW];
                m_ba = 3'(w);
                m_fl = {f_cas[w], f_ras[w], f_we[w], f_cmd[w],
                        f_rd[w], f_wr[w], f_mw[w]};
                m_last = w;
                if (f_rd[w] | f_wr[w]) begin
                    if (f_wr[w] != m_dir) begin
                        m_dir = f_wr[w];
                        m_streak = 1;
                    end else if (m_streak < SMAX) begin
                        m_streak = m_streak + 1;
                    end
                end
            end else if (m_valid && cmd_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        logic [NUM-1:0] er;
        int w;
        if (chk_en) begin
            er = '0;
            if (rst) begin
                w = pick();
                if (w >= 0 && (!m_valid || cmd_ready)) er[w] = 1'b1;
            end
            chk("model_req_ready", 64'(rr), 64'(er));
            chk("model_cmd_valid", 64'(cmd_valid), 64'(m_valid));
            chk("model_payload",
                64'({p_a, p_ba, p_cas, p_ras, p_we, p_cmd, p_rd, p_wr, p_mw}),
                64'({m_a, m_ba, m_fl}));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // kind: 0 = non-CAS (ACT/PRE/REF), 1 = read, 2 = write
    task automatic set_req(int i, bit val, int kind, logic [AW-1:0] addr);
        v[i]     = val;
        f_cmd[i] = (kind == 0);
        f_rd[i]  = (kind == 1);
        f_wr[i]  = (kind == 2);
        f_cas[i] = (kind != 0);
        f_ras[i] = (kind == 0);
        f_we[i]  = (kind == 2);
        f_mw[i]  = 1'b0;
        a[i*AW +: AW] = addr;
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b0;
        v = '0;
        cmd_ready = 1'b1;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic run_seq(input int exp_q[$], input int drop_after);
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k > 0) begin
                tick();
                if (exp_q[k-1] == drop_after) v[drop_after] = 1'b0;
            end
            @(negedge clk);
            chk("seq_grant", 64'(rr), 64'(1) << exp_q[k]);
        end
    endtask

    initial begin
        #1 rst = 1'b0;
        #1 chk_en = 1'b1;

        for (int i = 0; i < NUM; i++) set_req(i, 1'b1, 1, AW'(32'h100 + i));
        cmd_ready = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("reset_cmd_valid", 64'(cmd_valid), 64'(0));
            chk("reset_req_ready", 64'(rr), 64'(0));
        end

        tick();
        rst = 1'b1;
        for (int k = 0; k < 9; k++) begin
            if (k > 0) tick();
            @(negedge clk);
            chk("fair_req_ready", 64'(rr), 64'(1) << (k % 8));
            if (k > 0) begin
                chk("fair_ba", 64'(p_ba), 64'((k - 1) % 8));
                chk("fair_addr", 64'(p_a), 64'(32'h100 + (k - 1) % 8));
            end
        end

        tick();
        cmd_ready = 1'b0;
        for (int j = 0; j < 5; j++) begin
            if (j > 0) tick();
            @(negedge clk);
            chk("bp_req_ready", 64'(rr), 64'(0));
            chk("bp_valid", 64'(cmd_valid), 64'(1));
            chk("bp_ba", 64'(p_ba), 64'(0));
            chk("bp_addr", 64'(p_a), 64'(32'h100));
        end
        tick();
        cmd_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_grant", 64'(rr), 64'(8'h02));

        do_reset();
        set_req(6, 1'b1, 1, AW'(32'h66));
        @(negedge clk);
        chk("sparse_first6", 64'(rr), 64'(8'h40));
        tick();
        set_req(1, 1'b1, 1, AW'(32'h11));
        @(negedge clk);
        chk("sparse_wrap1", 64'(rr), 64'(8'h02));
        chk("sparse_ba6", 64'(p_ba), 64'(6));
        tick();
        @(negedge clk);
        chk("sparse_then6", 64'(rr), 64'(8'h40));
        chk("sparse_ba1", 64'(p_ba), 64'(1));
        chk("sparse_addr1", 64'(p_a), 64'(32'h11));

`ifdef CMD_ARB_RW_GROUP_EN
        do_reset();
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, 1, AW'(i));
        set_req(4, 1'b1, 2, AW'(32'h44));
        run_seq('{0, 1, 2, 3, 4, 0, 1}, 4);

        do_reset();
        set_req(0, 1'b1, 1, AW'(32'h0));
        set_req(1, 1'b1, 1, AW'(32'h1));
        set_req(2, 1'b1, 0, AW'(32'h2));
        set_req(3, 1'b1, 1, AW'(32'h3));
        set_req(5, 1'b1, 2, AW'(32'h5));
        run_seq('{0, 1, 2, 3, 0, 2, 5, 2, 5}, -1);
`endif

        do_reset();
        for (int c = 0; c < 600; c++) begin
            tick();
            v = 8'($urandom) & 8'($urandom | $urandom);
            for (int i = 0; i < NUM; i++) begin
                set_req(i, v[i], int'($urandom_range(0, 2)), AW'($urandom));
                f_cas[i] = 1'($urandom);
                f_ras[i] = 1'($urandom);
                f_we[i]  = 1'($urandom);
                f_mw[i]  = 1'($urandom);
            end
            cmd_ready = ($urandom_range(0, 3) != 0);
            if (c == 300) begin
                #2 rst = 1'b0;
                #10 rst = 1'b1;
            end
        end

        tick();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
